branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Initiator-side sequencer for the registered `alu`: accepts a conditional-branch request, drives `alu` through two operations and returns a taken/target response.
- Operation 1: SUB rs1−rs2 for the comparison.
- Operation 2: ADD pc+imm for the target.
- Sits between decode/issue and the PC-update logic. Converts `alu` flags (zero, sign, 33rd-bit borrow) into RV32I branch decisions.

Parameters:
- XLEN, 32, datapath width; must match `alu` operand width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  branch request valid.
- req_ready  out  1  block can accept a request.
- req_funct3  in  3  RV32I branch funct3.
- req_rs1  in  XLEN  first comparison operand.
- req_rs2  in  XLEN  second comparison operand.
- req_pc  in  XLEN  branch instruction PC.
- req_imm  in  XLEN  sign-extended B-immediate.
- alu_ce  out  1  drives `alu` ce.
- alu_op  out  alu_op_t  drives `alu` op_sel.
- alu_operand1  out  XLEN  drives `alu` operand1.
- alu_operand2  out  XLEN  drives `alu` operand2.
- alu_result  in  XLEN  `alu` result (registered in `alu`).
- alu_flags  in  alu_flags_t  `alu` zero/sign/overflow.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_taken  out  1  branch taken.
- resp_target  out  XLEN  pc+imm.
- resp_illegal  out  1  funct3 not a branch encoding.

Behaviour:
- Reset (rst_n low at posedge): state IDLE. Outputs: req_ready=1, resp_valid=0, resp_taken=0, resp_illegal=0, resp_target=0, alu_ce=0, alu_op=ADD, operands 0. Reset mid-operation abandons the request; no response is produced.
- States: IDLE, CMP, EVAL, CAPT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch funct3/rs1/rs2/pc/imm.
  - funct3 ∈ {000,001,100,101,110,111} → CMP.
  - funct3 ∈ {010,011} → RESP with illegal=1, taken=0, target=0; ALU never enabled.
- CMP: alu_ce=1, alu_op=SUB, operand1=rs1, operand2=rs2 → EVAL.
- EVAL:
  - Sample alu_flags/alu_result (SUB result).
  - eq = flags.zero.
  - ltu = flags.overflow (borrow).
  - Signed overflow v = (rs1[31]≠rs2[31]) & (alu_result[31]≠rs1[31]); lt = flags.sign ^ v.
  - Register taken per funct3: BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
  - Same cycle: alu_ce=1, alu_op=ADD, operand1=pc, operand2=imm → CAPT.
- CAPT: resp_target ← alu_result (mod 2^XLEN; wrap-around ignored, overflow flag not used) → RESP.
- RESP:
  - resp_valid=1; taken/target/illegal stable until handshake.
  - On resp_ready: → IDLE, resp_valid=0 next cycle.
- req_ready=0 in every state except IDLE, so there are no back-to-back accepts. A new request is accepted only in IDLE, i.e. the cycle after the RESP handshake.
- alu_ce=0 in IDLE, CAPT and RESP, so the `alu` result holds.
- Latency, legal branch: 4 cycles from accept to resp_valid.
- Latency, illegal funct3: 1 cycle from accept to resp_valid.
- Throughput: at most 1 request per 5 cycles.
- req_* inputs are ignored when not in IDLE.
- resp_ready asserted outside RESP has no effect.

Test Plan:
- Reset mid-CMP: pulse rst_n low → next cycle IDLE, req_ready=1, resp_valid=0, alu_ce=0. A later request completes normally.
- BEQ, rs1=rs2=0x1234, pc=0x100, imm=0x20:
  - resp_valid exactly 4 cycles after accept; taken=1, target=0x120.
  - alu_ce seen for SUB then ADD, one cycle each.
- BLT vs BLTU, rs1=0xFFFFFFFF, rs2=0x00000001:
  - BLT → taken=1 (−1<1).
  - BLTU → taken=0.
  - BGEU → taken=1.
- Signed-overflow compare, rs1=0x80000000, rs2=0x00000001:
  - BLT → taken=1 (v=1, sign=0).
  - BGE → taken=0.
- Illegal funct3=010 → resp_valid 1 cycle after accept, illegal=1, taken=0, alu_ce never asserted.
- Backpressure and target wrap-around:
  - Hold resp_ready=0 for 5 cycles in RESP → outputs stable, req_ready=0, a new req_valid is not accepted.
  - pc=0xFFFFFFF0, imm=0x20 → target=0x00000010.

Source files
------------

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//
// Initiator-side sequencer for a registered ALU. It accepts one RV32I
// conditional branch, runs a SUB (rs1 - rs2) through the ALU to get the
// comparison flags, then runs an ADD (pc + imm) to get the target. The
// result goes out as a taken/target response with a valid/ready handshake.
//
// ALU interface encoding used by this block:
//   alu_op    : 4'd0 = ADD, 4'd1 = SUB
//   alu_flags : [2] zero, [1] sign, [0] overflow (carry/borrow out of the MSB)
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (accepted only in IDLE)
//   req_funct3/rs1/rs2/pc/imm       branch request payload
//   alu_ce/alu_op/alu_operand1/2    drive the ALU
//   alu_result/alu_flags            registered ALU outputs
//   resp_valid/resp_ready           response handshake
//   resp_taken/resp_target          branch decision and pc+imm
//   resp_illegal                    funct3 is not a branch encoding
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  output logic            alu_ce,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  input  logic [XLEN-1:0] alu_result,
  input  logic [2:0]      alu_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_target,
  output logic            resp_illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    EVAL = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t          state_reg,   state_next;
  logic [2:0]      funct3_reg,  funct3_next;
  logic [XLEN-1:0] rs1_reg,     rs1_next;
  logic [XLEN-1:0] rs2_reg,     rs2_next;
  logic [XLEN-1:0] pc_reg,      pc_next;
  logic [XLEN-1:0] imm_reg,     imm_next;
  logic            taken_reg,   taken_next;
  logic [XLEN-1:0] target_reg,  target_next;
  logic            illegal_reg, illegal_next;

  // Comparison terms derived from the SUB result seen in EVAL.
  logic flag_zero, flag_sign, flag_borrow;
  logic eq, ltu, lt, sgn_ovf, cond;

  assign flag_zero   = alu_flags[2];
  assign flag_sign   = alu_flags[1];
  assign flag_borrow = alu_flags[0];

  always_comb begin
    eq      = flag_zero;
    ltu     = flag_borrow;
    // Signed overflow of rs1 - rs2: operands differ in sign and the result
    // sign differs from rs1. The true signed "less than" is sign ^ overflow.
    sgn_ovf = (rs1_reg[XLEN-1] != rs2_reg[XLEN-1]) &&
              (alu_result[XLEN-1] != rs1_reg[XLEN-1]);
    lt      = flag_sign ^ sgn_ovf;
    cond    = 1'b0;
    case (funct3_reg)
      3'b000:  cond = eq;    // BEQ
      3'b001:  cond = !eq;   // BNE
      3'b100:  cond = lt;    // BLT
      3'b101:  cond = !lt;   // BGE
      3'b110:  cond = ltu;   // BLTU
      3'b111:  cond = !ltu;  // BGEU
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    funct3_next  = funct3_reg;
    rs1_next     = rs1_reg;
    rs2_next     = rs2_reg;
    pc_next      = pc_reg;
    imm_next     = imm_reg;
    taken_next   = taken_reg;
    target_next  = target_reg;
    illegal_next = illegal_reg;

    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    alu_ce       = 1'b0;
    alu_op       = ALU_ADD;
    alu_operand1 = '0;
    alu_operand2 = '0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_next  = req_funct3;
          rs1_next     = req_rs1;
          rs2_next     = req_rs2;
          pc_next      = req_pc;
          imm_next     = req_imm;
          taken_next   = 1'b0;
          target_next  = '0;
          // funct3 010/011 are the only non-branch encodings.
          if (req_funct3[2:1] == 2'b01) begin
            illegal_next = 1'b1;
            state_next   = RESP;
          end else begin
            illegal_next = 1'b0;
            state_next   = CMP;
          end
        end
      end
      CMP: begin
        alu_ce       = 1'b1;
        alu_op       = ALU_SUB;
        alu_operand1 = rs1_reg;
        alu_operand2 = rs2_reg;
        state_next   = EVAL;
      end
      EVAL: begin
        // SUB result is visible now; issue the target ADD in the same cycle.
        taken_next   = cond;
        alu_ce       = 1'b1;
        alu_op       = ALU_ADD;
        alu_operand1 = pc_reg;
        alu_operand2 = imm_reg;
        state_next   = CAPT;
      end
      CAPT: begin
        target_next = alu_result;
        state_next  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      funct3_reg  <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      pc_reg      <= '0;
      imm_reg     <= '0;
      taken_reg   <= 1'b0;
      target_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      funct3_reg  <= funct3_next;
      rs1_reg     <= rs1_next;
      rs2_reg     <= rs2_next;
      pc_reg      <= pc_next;
      imm_reg     <= imm_next;
      taken_reg   <= taken_next;
      target_reg  <= target_next;
      illegal_reg <= illegal_next;
    end
  end

  assign resp_taken   = taken_reg;
  assign resp_target  = target_reg;
  assign resp_illegal = illegal_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//
// Drives branch_resolver against a small registered ALU model and checks
// each response against RV32I branch semantics computed directly with
// signed/unsigned comparisons and 32-bit addition.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2, req_pc, req_imm;
  logic        alu_ce;
  logic [3:0]  alu_op;
  logic [31:0] alu_operand1, alu_operand2;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [31:0] resp_target;
  logic        resp_illegal;

  int checks = 0;
  int errors = 0;

  branch_resolver #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_pc       (req_pc),
    .req_imm      (req_imm),
    .alu_ce       (alu_ce),
    .alu_op       (alu_op),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_taken   (resp_taken),
    .resp_target  (resp_target),
    .resp_illegal (resp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU model: flags = {zero, sign, carry/borrow}.
  initial begin
    alu_result = '0;
    alu_flags  = '0;
  end
  always @(posedge clk) begin
    logic [32:0] wide;
    if (alu_ce) begin
      if (alu_op == ALU_SUB) wide = {1'b0, alu_operand1} - {1'b0, alu_operand2};
      else                   wide = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      alu_result <= wide[31:0];
      alu_flags  <= {wide[31:0] == 32'd0, wide[31], wide[32]};
    end
  end

  // Reference: RV32I branch semantics.
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full branch transaction: accept, wait for response, hold it under
  // backpressure for 'hold' cycles, then handshake.
  task automatic run_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm, input int hold,
                            input string name);
    logic        exp_taken, exp_ill;
    logic [31:0] exp_tgt;
    int          guard, lat, ce_n;
    logic [3:0]  ops [2];
    logic [31:0] o1s [2];
    logic [31:0] o2s [2];
    int          err0;
    err0      = errors;
    exp_ill   = ref_illegal(f3);
    exp_taken = exp_ill ? 1'b0 : ref_taken(f3, a, b);
    exp_tgt   = exp_ill ? 32'd0 : pc + imm;

    guard = 0;
    while (!req_ready && guard < 20) begin tick(); guard++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s ready_timeout req_ready=%0b required=1", name, req_ready);
      return;
    end

    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_pc = pc; req_imm = imm;
    tick();
    req_valid  = 1'b0;
    // Scramble payload afterwards; it must be ignored outside IDLE.
    req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
    req_pc     = $urandom;     req_imm = $urandom;

    lat  = 1;
    ce_n = 0;
    while (!resp_valid && lat < 20) begin
      resp_ready = 1'($urandom);  // no effect outside RESP
      if (alu_ce) begin
        if (ce_n < 2) begin ops[ce_n] = alu_op; o1s[ce_n] = alu_operand1; o2s[ce_n] = alu_operand2; end
        ce_n++;
      end
      tick();
      lat++;
    end
    resp_ready = 1'b0;

    checks++;
    if (lat !== (exp_ill ? 1 : 4)) begin
      errors++;
      $display("FAIL %s latency got=%0d required=%0d", name, lat, exp_ill ? 1 : 4);
    end
    checks++;
    if (ce_n !== (exp_ill ? 0 : 2)) begin
      errors++;
      $display("FAIL %s alu_ce_cycles got=%0d required=%0d", name, ce_n, exp_ill ? 0 : 2);
    end
    if (!exp_ill && ce_n == 2) begin
      checks++;
      if (ops[0] !== ALU_SUB || o1s[0] !== a || o2s[0] !== b ||
          ops[1] !== ALU_ADD || o1s[1] !== pc || o2s[1] !== imm) begin
        errors++;
        $display("FAIL %s alu_seq got=%0d:%h:%h,%0d:%h:%h required=%0d:%h:%h,%0d:%h:%h", name,
                 ops[0], o1s[0], o2s[0], ops[1], o1s[1], o2s[1],
                 ALU_SUB, a, b, ALU_ADD, pc, imm);
      end
    end

    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_taken !== exp_taken || resp_target !== exp_tgt ||
          resp_illegal !== exp_ill || req_ready !== 1'b0 || alu_ce !== 1'b0) begin
        errors++;
        $display("FAIL %s resp_cycle%0d got v=%0b t=%0b tgt=%h ill=%0b rdy=%0b ce=%0b required v=1 t=%0b tgt=%h ill=%0b rdy=0 ce=0",
                 name, h, resp_valid, resp_taken, resp_target, resp_illegal, req_ready, alu_ce,
                 exp_taken, exp_tgt, exp_ill);
      end
      if (h < hold) begin
        req_valid = 1'b1;  // must not be accepted while busy
        tick();
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake got v=%0b rdy=%0b required v=0 rdy=1", name, resp_valid, req_ready);
    end
    $display("txn %s f3=%0d rs1=%h rs2=%h pc=%h imm=%h -> taken=%0b target=%h illegal=%0b lat=%0d hold=%0d %s",
             name, f3, a, b, pc, imm, exp_taken, exp_tgt, exp_ill, lat, hold,
             (errors == err0) ? "ok" : "bad");
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_taken !== 1'b0 || resp_illegal !== 1'b0 ||
        resp_target !== 32'd0 || alu_ce !== 1'b0 || alu_op !== ALU_ADD ||
        alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b v=%0b t=%0b ill=%0b tgt=%h ce=%0b op=%0d o1=%h o2=%h required rdy=1 all else 0",
               req_ready, resp_valid, resp_taken, resp_illegal, resp_target, alu_ce, alu_op,
               alu_operand1, alu_operand2);
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_reset_mid_cmp;
    int seen;
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h5; req_rs2 = 32'h5;
    req_pc = 32'h40; req_imm = 32'h8;
    tick();
    req_valid = 1'b0;
    checks++;
    if (alu_ce !== 1'b1 || alu_op !== ALU_SUB) begin
      errors++;
      $display("FAIL mid_cmp_entry got ce=%0b op=%0d required ce=1 op=%0d", alu_ce, alu_op, ALU_SUB);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || alu_ce !== 1'b0) begin
      errors++;
      $display("FAIL mid_cmp_reset got rdy=%0b v=%0b ce=%0b required rdy=1 v=0 ce=0", req_ready, resp_valid, alu_ce);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid || alu_ce) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_cmp_abandon got active_cycles=%0d required=0", seen);
    end
    $display("txn reset_mid_cmp done");
    run_branch(3'b001, 32'h7, 32'h9, 32'h200, 32'h10, 0, "after_reset_bne");
  endtask

  task automatic test_directed;
    run_branch(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 0, "beq_equal");
    run_branch(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h4, 0, "blt_neg1_1");
    run_branch(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h4, 0, "bltu_neg1_1");
    run_branch(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h4, 0, "bgeu_neg1_1");
    run_branch(3'b100, 32'h8000_0000, 32'h1, 32'h10, 32'hFFFF_FFF0, 0, "blt_ovf");
    run_branch(3'b101, 32'h8000_0000, 32'h1, 32'h10, 32'hFFFF_FFF0, 0, "bge_ovf");
    run_branch(3'b010, 32'h1, 32'h2, 32'h300, 32'h8, 0, "illegal_010");
    run_branch(3'b011, 32'h1, 32'h1, 32'h300, 32'h8, 2, "illegal_011");
  endtask

  task automatic test_backpressure_wrap;
    run_branch(3'b001, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h20, 5, "bp_wrap");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        2:       b = {a[31], 31'($urandom)};
        default: b = $urandom;
      endcase
      run_branch(3'($urandom), a, b, $urandom, $urandom, $urandom_range(0, 3),
                 $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; req_pc = '0; req_imm = '0;
    #1;
    test_reset();
    test_reset_mid_cmp();
    test_directed();
    test_backpressure_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
